// File: rtl/fir_decimator_buffer_pkg.sv
// Shared widths and helpers for the FIR decimator buffer slice.
// Sample width matches the upstream FIR output; drop counter is a saturating byte.
package fir_decimator_buffer_pkg;

  localparam int SAMPLE_W   = 17;
  localparam int DROP_CNT_W = 8;
  localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

  // Elaboration-time ceiling log2, kept for tools with weak $clog2 support.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fir_decimator_buffer_if.sv
// Sample-in / decimated-word-out bundle of the FIR decimator buffer.
// master = the buffer itself, slave = the filter/sink environment around it.
interface fir_decimator_buffer_if
  import fir_decimator_buffer_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int FIFO_DEPTH = 8
);

  localparam int LEVEL_W = clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0]     data_in;
  logic                  in_valid;
  logic [DATA_W-1:0]     out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] drop_count;
  logic [LEVEL_W-1:0]    fill_level;

  modport master (
    input  data_in,
    input  in_valid,
    input  out_ready,
    output out_data,
    output out_valid,
    output overflow,
    output drop_count,
    output fill_level
  );

  modport slave (
    output data_in,
    output in_valid,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  overflow,
    input  drop_count,
    input  fill_level
  );

endinterface

// File: rtl/fir_decimator_buffer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head visible the edge after a push into empty.
// Push while full is ignored unless a pop happens on the same edge; pop while empty is ignored.
module fir_decimator_buffer_sync_fifo
  import fir_decimator_buffer_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      push,
  input  logic [DATA_W-1:0]         din,
  input  logic                      pop,
  output logic [DATA_W-1:0]         dout,
  output logic                      full,
  output logic                      empty,
  output logic [clog2(DEPTH):0]     level
);

  localparam int PTR_W   = clog2(DEPTH);
  localparam int LEVEL_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [LEVEL_W-1:0] count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LEVEL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Zero the head while empty so stale storage never leaks onto the bus.
  assign dout  = empty ? '0 : mem[rd_ptr];
  assign level = count;

endmodule

// File: rtl/fir_decimator_buffer.sv
// Integrate-and-dump decimator (average of 2**DECIM_LOG2 samples) feeding an FWFT FIFO.
// Word appears the edge the last sample lands; when full and not draining the word is dropped and counted.
module fir_decimator_buffer
  import fir_decimator_buffer_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  fir_decimator_buffer_if.master bus
);

  localparam int ACC_W   = DATA_W + DECIM_LOG2;
  localparam int LEVEL_W = clog2(FIFO_DEPTH) + 1;

  logic [ACC_W-1:0]      acc;
  logic [ACC_W-1:0]      sum;
  logic [DECIM_LOG2-1:0] phase;
  logic                  dump;
  logic [DATA_W-1:0]     avg;

  logic                  fifo_pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_W-1:0]     fifo_dout;
  logic [LEVEL_W-1:0]    fifo_level;
  logic                  drop;

  logic                  overflow_q;
  logic [DROP_CNT_W-1:0] drop_count_q;

  // Accumulator carries DECIM_LOG2 guard bits, so a full block of max samples fits.
  assign sum  = acc + ACC_W'(bus.data_in);
  assign dump = bus.in_valid && (&phase);
  assign avg  = sum[ACC_W-1:DECIM_LOG2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      phase <= '0;
    end else if (bus.in_valid) begin
      if (dump) begin
        acc   <= '0;
        phase <= '0;
      end else begin
        acc   <= sum;
        phase <= phase + 1'b1;
      end
    end
  end

  assign fifo_pop = bus.out_ready && !fifo_empty;
  assign drop     = dump && fifo_full && !fifo_pop;

  fir_decimator_buffer_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (dump),
    .din   (avg),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (drop_count_q != DROP_CNT_MAX) begin
        drop_count_q <= drop_count_q + 1'b1;
      end
    end
  end

  assign bus.out_valid  = !fifo_empty;
  assign bus.out_data   = fifo_dout;
  assign bus.fill_level = fifo_level;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_fir_decimator_buffer.sv
// Directed bench for fir_decimator_buffer with a queue scoreboard of expected FIFO words.
module tb_fir_decimator_buffer;
  import fir_decimator_buffer_pkg::*;

  localparam int DW    = 17;
  localparam int DL    = 2;
  localparam int DECIM = 4;
  localparam int DEPTH = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;

  always #5 clock = ~clock;

  fir_decimator_buffer_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

  fir_decimator_buffer #(
    .DATA_W     (DW),
    .DECIM_LOG2 (DL),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int tests  = 0;
  int failed = 0;

  logic [DW-1:0] sb_q[$];
  int            m_acc;
  int            m_phase;
  int            m_drops;
  logic          m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [DW-1:0] head;
    head = (sb_q.size() > 0) ? sb_q[0] : '0;
    check({tag, "/out_valid"},  32'(bus.out_valid),  32'(sb_q.size() > 0));
    check({tag, "/out_data"},   32'(bus.out_data),   32'(head));
    check({tag, "/fill_level"}, 32'(bus.fill_level), 32'(sb_q.size()));
    check({tag, "/overflow"},   32'(bus.overflow),   32'(m_ovf));
    check({tag, "/drop_count"}, 32'(bus.drop_count), 32'(m_drops));
  endtask

  // Called at a falling edge: drive, check current outputs, advance model, move to next falling edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input string tag);
    int   lvl;
    bit   pop;
    int   sum;
    logic [DW-1:0] avg;
    bus.in_valid  = v;
    bus.data_in   = d;
    bus.out_ready = r;
    check_outputs(tag);
    lvl = sb_q.size();
    pop = (lvl > 0) && r;
    if (pop) void'(sb_q.pop_front());
    if (v) begin
      if (m_phase == DECIM - 1) begin
        sum = m_acc + int'(d);
        avg = DW'(sum >> DL);
        if (lvl < DEPTH || pop) begin
          sb_q.push_back(avg);
        end else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
        m_acc   = 0;
        m_phase = 0;
      end else begin
        m_acc   = m_acc + int'(d);
        m_phase = m_phase + 1;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic apply_reset(input int n);
    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.data_in   = DW'(100);
    bus.out_ready = 1'b0;
    sb_q.delete();
    m_acc   = 0;
    m_phase = 0;
    m_drops = 0;
    m_ovf   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_outputs("reset");
    end
    reset = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;
    m_acc   = 0;
    m_phase = 0;
    m_drops = 0;
    m_ovf   = 1'b0;

    // Reset held with a live input stream: nothing may be pushed.
    apply_reset(3);

    // Basic decimation, first-word latency and full-scale block.
    cycle(1'b1, DW'(10), 1'b1, "dec");
    cycle(1'b1, DW'(20), 1'b1, "dec");
    cycle(1'b1, DW'(30), 1'b1, "dec");
    cycle(1'b1, DW'(41), 1'b1, "dec");
    check("dec_first_valid", 32'(bus.out_valid), 32'd1);
    check("dec_first_word",  32'(bus.out_data),  32'd25);
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(131071), 1'b1, "dec_max");
    check("dec_max_word", 32'(bus.out_data), 32'd131071);
    cycle(1'b0, '0, 1'b1, "dec_idle");
    check("dec_drained", 32'(bus.out_valid), 32'd0);

    // Gaps freeze the integrator.
    cycle(1'b1, DW'(8), 1'b1, "gap");
    cycle(1'b0, DW'(8), 1'b1, "gap");
    cycle(1'b1, DW'(8), 1'b1, "gap");
    cycle(1'b1, DW'(8), 1'b1, "gap");
    cycle(1'b0, DW'(8), 1'b1, "gap");
    check("gap_no_word_yet", 32'(bus.out_valid), 32'd0);
    cycle(1'b1, DW'(8), 1'b1, "gap");
    check("gap_word", 32'(bus.out_data), 32'd8);
    cycle(1'b0, '0, 1'b1, "gap_idle");

    // Backpressure: 40 blocks into an 8-deep FIFO, 32 drops.
    for (int blk = 0; blk < 40; blk++) begin
      for (int k = 0; k < DECIM; k++) cycle(1'b1, DW'(1000 + blk), 1'b0, "bp_fill");
    end
    check("bp_level",    32'(bus.fill_level), 32'd8);
    check("bp_overflow", 32'(bus.overflow),   32'd1);
    check("bp_drops",    32'(bus.drop_count), 32'd32);
    for (int i = 0; i < DEPTH; i++) begin
      check("bp_order", 32'(bus.out_data), 32'(1000 + i));
      cycle(1'b0, '0, 1'b1, "bp_drain");
    end
    check("bp_empty", 32'(bus.out_valid), 32'd0);

    // Full FIFO with a pop on the dump edge: word accepted, no new drop.
    for (int blk = 0; blk < DEPTH; blk++) begin
      for (int k = 0; k < DECIM; k++) cycle(1'b1, DW'(2000 + blk), 1'b0, "fp_fill");
    end
    check("fp_full", 32'(bus.fill_level), 32'd8);
    for (int k = 0; k < DECIM - 1; k++) cycle(1'b1, DW'(3000), 1'b0, "fp_block");
    cycle(1'b1, DW'(3000), 1'b1, "fp_dump");
    check("fp_level", 32'(bus.fill_level), 32'd8);
    check("fp_drops", 32'(bus.drop_count), 32'd32);
    check("fp_head",  32'(bus.out_data),   32'd2001);
    for (int i = 0; i < DEPTH; i++) begin
      check("fp_order", 32'(bus.out_data), (i < DEPTH - 1) ? 32'(2001 + i) : 32'd3000);
      cycle(1'b0, '0, 1'b1, "fp_drain");
    end

    // Reset mid-block with queued words: partial sum and FIFO discarded.
    for (int k = 0; k < 3 * DECIM; k++) cycle(1'b1, DW'(60), 1'b0, "mr_fill");
    cycle(1'b1, DW'(50), 1'b0, "mr_part");
    cycle(1'b1, DW'(50), 1'b0, "mr_part");
    check("mr_queued", 32'(bus.fill_level), 32'd3);
    apply_reset(2);
    check("mr_cleared_level", 32'(bus.fill_level), 32'd0);
    check("mr_cleared_drops", 32'(bus.drop_count), 32'd0);
    for (int k = 0; k < DECIM; k++) cycle(1'b1, DW'(4), 1'b0, "mr_block");
    check("mr_word",  32'(bus.out_data),   32'd4);
    check("mr_level", 32'(bus.fill_level), 32'd1);
    cycle(1'b0, '0, 1'b1, "mr_drain");
    cycle(1'b0, '0, 1'b1, "mr_idle");
    check("mr_empty", 32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
